// File: rtl/hgcal_fast_command_scheduler.sv
// Fast-control command sequencer: one 8-bit command per bunch crossing.
// Tracks BX/orbit, forces BCR at BCR_BX and arbitrates L1A, calibration, ECR and link reset.
module hgcal_fast_command_scheduler #(
    parameter int         ORBIT_LEN     = 3564,
    parameter int         BCR_BX        = 0,
    parameter int         CAL_L1A_DELAY = 20,
    parameter logic [7:0] IDLE_CODE     = 8'hAC,
    parameter logic [7:0] L1A_CODE      = 8'h2D,
    parameter logic [7:0] BCR_CODE      = 8'h33,
    parameter logic [7:0] CAL_CODE      = 8'h4B,
    parameter logic [7:0] ECR_CODE      = 8'h55,
    parameter logic [7:0] LRST_CODE     = 8'h66
) (
    input  logic        clk40,
    input  logic        rstn,
    input  logic        enable,
    input  logic        l1a_req,
    input  logic        calib_req,
    input  logic        ecr_req,
    input  logic        linkreset_req,
    output logic [7:0]  command,
    output logic [11:0] bx_counter,
    output logic [15:0] orbit_counter,
    output logic        l1a_sent,
    output logic        ecr_ack,
    output logic        linkreset_ack,
    output logic        calib_reject,
    output logic        l1a_overflow
);

    localparam int DLY_W = $clog2(CAL_L1A_DELAY) + 1;

    typedef enum logic [1:0] {C_IDLE, C_PULSE, C_WAIT} cal_state_t;

    logic [7:0]       command_reg, command_next;
    logic [11:0]      bx_reg, bx_next;
    logic [15:0]      orbit_reg, orbit_next;
    logic             l1a_sent_reg, l1a_sent_next;
    logic             calib_reject_reg, calib_reject_next;
    logic             l1a_overflow_reg, l1a_overflow_next;
    logic [2:0]       pending_reg, pending_next;
    cal_state_t       cal_state_reg, cal_state_next;
    logic [DLY_W-1:0] delay_reg, delay_next;

    logic       bcr_slot, cal_due, cal_blocked;
    logic       emit_pending, emit_cal_l1a, emit_cal;
    logic [3:0] pending_sum;
    logic [1:0] lvl_req, lvl_pend, lvl_ack, lvl_issue;

    always_comb begin
        bx_next    = bx_reg + 12'd1;
        orbit_next = orbit_reg;
        if (bx_reg == 12'(ORBIT_LEN - 1)) begin
            bx_next    = '0;
            orbit_next = orbit_reg + 16'd1;
        end
    end

    assign bcr_slot = (bx_next == 12'(BCR_BX));
    assign cal_due  = (cal_state_reg == C_WAIT) && (delay_reg == '0);

    // One slot per BX; BCR wins even when disabled.
    always_comb begin
        command_next = IDLE_CODE;
        emit_pending = 1'b0;
        emit_cal_l1a = 1'b0;
        emit_cal     = 1'b0;
        cal_blocked  = 1'b0;
        lvl_issue    = 2'b00;
        if (bcr_slot) begin
            command_next = BCR_CODE;
            cal_blocked  = enable & cal_due;
        end else if (enable) begin
            if (cal_due) begin
                command_next = L1A_CODE;
                emit_cal_l1a = 1'b1;
            end else if (pending_reg != 3'd0) begin
                command_next = L1A_CODE;
                emit_pending = 1'b1;
            end else if (cal_state_reg == C_PULSE) begin
                command_next = CAL_CODE;
                emit_cal     = 1'b1;
            end else if (lvl_pend[0]) begin
                command_next = ECR_CODE;
                lvl_issue[0] = 1'b1;
            end else if (lvl_pend[1]) begin
                command_next = LRST_CODE;
                lvl_issue[1] = 1'b1;
            end
        end
    end

    assign l1a_sent_next = emit_cal_l1a | emit_pending;

    // A blocked calibration L1A is folded into the pending count.
    always_comb begin
        pending_sum       = {1'b0, pending_reg} + {3'd0, l1a_req} + {3'd0, cal_blocked}
                          - {3'd0, emit_pending};
        pending_next      = (pending_sum > 4'd7) ? 3'd7 : pending_sum[2:0];
        l1a_overflow_next = (pending_sum > 4'd7);
        if (!enable) begin
            pending_next      = 3'd0;
            l1a_overflow_next = 1'b0;
        end
    end

    always_comb begin
        cal_state_next    = cal_state_reg;
        delay_next        = delay_reg;
        calib_reject_next = 1'b0;
        if (!enable) begin
            cal_state_next = C_IDLE;
            delay_next     = '0;
        end else begin
            calib_reject_next = calib_req && (cal_state_reg != C_IDLE);
            case (cal_state_reg)
                C_IDLE: begin
                    if (calib_req)
                        cal_state_next = C_PULSE;
                end
                C_PULSE: begin
                    if (emit_cal) begin
                        cal_state_next = C_WAIT;
                        delay_next     = DLY_W'(CAL_L1A_DELAY - 1);
                    end
                end
                C_WAIT: begin
                    if (cal_due)
                        cal_state_next = C_IDLE;
                    else
                        delay_next = delay_reg - DLY_W'(1);
                end
                default: cal_state_next = C_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk40 or negedge rstn) begin
        if (!rstn) begin
            command_reg      <= IDLE_CODE;
            bx_reg           <= 12'(ORBIT_LEN - 1);
            orbit_reg        <= '0;
            l1a_sent_reg     <= 1'b0;
            calib_reject_reg <= 1'b0;
            l1a_overflow_reg <= 1'b0;
            pending_reg      <= 3'd0;
            cal_state_reg    <= C_IDLE;
            delay_reg        <= '0;
        end else begin
            command_reg      <= command_next;
            bx_reg           <= bx_next;
            orbit_reg        <= orbit_next;
            l1a_sent_reg     <= l1a_sent_next;
            calib_reject_reg <= calib_reject_next;
            l1a_overflow_reg <= l1a_overflow_next;
            pending_reg      <= pending_next;
            cal_state_reg    <= cal_state_next;
            delay_reg        <= delay_next;
        end
    end

    // Level-held requests (0 = ECR, 1 = link reset); the sample taken while ack is showing is ignored.
    assign lvl_req = {linkreset_req, ecr_req};

    for (genvar gi = 0; gi < 2; gi++) begin : g_lvl
        logic pend_reg;
        logic ack_reg;
        always_ff @(posedge clk40 or negedge rstn) begin
            if (!rstn) begin
                pend_reg <= 1'b0;
                ack_reg  <= 1'b0;
            end else begin
                pend_reg <= enable & ~lvl_issue[gi] & (pend_reg | (lvl_req[gi] & ~ack_reg));
                ack_reg  <= lvl_issue[gi];
            end
        end
        assign lvl_pend[gi] = pend_reg;
        assign lvl_ack[gi]  = ack_reg;
    end

    assign command       = command_reg;
    assign bx_counter    = bx_reg;
    assign orbit_counter = orbit_reg;
    assign l1a_sent      = l1a_sent_reg;
    assign calib_reject  = calib_reject_reg;
    assign l1a_overflow  = l1a_overflow_reg;
    assign ecr_ack       = lvl_ack[0];
    assign linkreset_ack = lvl_ack[1];

endmodule

// File: tb/tb_hgcal_fast_command_scheduler.sv
// Bench for hgcal_fast_command_scheduler: directed steps plus random traffic,
// each cycle compared against a rule-level model using absolute cycle times.
`timescale 1ns/1ps
module tb_hgcal_fast_command_scheduler;

    localparam int         ORBIT_LEN = 3564;
    localparam int         BCR_BX    = 0;
    localparam int         DELAY     = 20;
    localparam logic [7:0] IDLE      = 8'hAC;
    localparam logic [7:0] L1A       = 8'h2D;
    localparam logic [7:0] BCR       = 8'h33;
    localparam logic [7:0] CAL       = 8'h4B;
    localparam logic [7:0] ECR       = 8'h55;
    localparam logic [7:0] LRST      = 8'h66;

    logic        clk40 = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        l1a_req = 1'b0;
    logic        calib_req = 1'b0;
    logic        ecr_req = 1'b0;
    logic        linkreset_req = 1'b0;
    logic [7:0]  command;
    logic [11:0] bx_counter;
    logic [15:0] orbit_counter;
    logic        l1a_sent, ecr_ack, linkreset_ack, calib_reject, l1a_overflow;

    int total = 0;
    int bad = 0;

    // model state: phase 0 idle, 1 calib pulse wanted, 2 calib L1A scheduled at m_cal_t
    int         m_t, m_bx, m_orbit, m_pend, m_phase, m_cal_t;
    bit         m_ecr_p, m_lrst_p, m_ecr_prev, m_lrst_prev;
    logic [7:0] e_cmd;
    bit         e_l1a, e_ecr, e_lrst, e_rej, e_ovf;
    int         n_l1a, n_ecr;

    hgcal_fast_command_scheduler dut (
        .clk40(clk40), .rstn(rstn), .enable(enable), .l1a_req(l1a_req),
        .calib_req(calib_req), .ecr_req(ecr_req), .linkreset_req(linkreset_req),
        .command(command), .bx_counter(bx_counter), .orbit_counter(orbit_counter),
        .l1a_sent(l1a_sent), .ecr_ack(ecr_ack), .linkreset_ack(linkreset_ack),
        .calib_reject(calib_reject), .l1a_overflow(l1a_overflow)
    );

    always #12 clk40 = ~clk40;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h (bx %0d)", tag, got, exp, m_bx);
        end
    endtask

    task automatic model_reset();
        m_t = 0; m_bx = ORBIT_LEN - 1; m_orbit = 0; m_pend = 0; m_phase = 0; m_cal_t = -1;
        m_ecr_p = 0; m_lrst_p = 0; m_ecr_prev = 0; m_lrst_prev = 0;
        e_cmd = IDLE; e_l1a = 0; e_ecr = 0; e_lrst = 0; e_rej = 0; e_ovf = 0;
    endtask

    task automatic model_step();
        int v;
        int phase0;
        bit bcr, due, from_pend;
        m_t++;
        m_bx = (m_bx + 1) % ORBIT_LEN;
        if (m_bx == 0) m_orbit = (m_orbit + 1) % 65536;
        bcr = (m_bx == BCR_BX);
        due = enable && (m_phase == 2) && (m_t == m_cal_t);
        phase0 = m_phase;
        from_pend = 0;
        e_rej = 0; e_ovf = 0;
        e_cmd = IDLE;
        if (bcr) e_cmd = BCR;
        else if (enable) begin
            if (due) e_cmd = L1A;
            else if (m_pend > 0) begin e_cmd = L1A; from_pend = 1; end
            else if (m_phase == 1) e_cmd = CAL;
            else if (m_ecr_p) e_cmd = ECR;
            else if (m_lrst_p) e_cmd = LRST;
        end
        e_l1a = (e_cmd == L1A); e_ecr = (e_cmd == ECR); e_lrst = (e_cmd == LRST);
        if (!enable) begin
            m_pend = 0; m_phase = 0; m_ecr_p = 0; m_lrst_p = 0;
        end else begin
            v = m_pend + int'(l1a_req) + int'(due && bcr) - int'(from_pend);
            e_ovf = (v > 7);
            m_pend = (v > 7) ? 7 : v;
            if (due) m_phase = 0;
            if (e_cmd == CAL) begin m_phase = 2; m_cal_t = m_t + DELAY; end
            if (calib_req) begin
                if (phase0 != 0) e_rej = 1;
                else m_phase = 1;
            end
            m_ecr_p  = !e_ecr  && (m_ecr_p  || (ecr_req && !m_ecr_prev));
            m_lrst_p = !e_lrst && (m_lrst_p || (linkreset_req && !m_lrst_prev));
        end
        m_ecr_prev = e_ecr; m_lrst_prev = e_lrst;
    endtask

    task automatic check_all();
        chk("command", 16'(command), 16'(e_cmd));
        chk("bx_counter", 16'(bx_counter), 16'(m_bx));
        chk("orbit_counter", orbit_counter, 16'(m_orbit));
        chk("l1a_sent", 16'(l1a_sent), 16'(e_l1a));
        chk("ecr_ack", 16'(ecr_ack), 16'(e_ecr));
        chk("linkreset_ack", 16'(linkreset_ack), 16'(e_lrst));
        chk("calib_reject", 16'(calib_reject), 16'(e_rej));
        chk("l1a_overflow", 16'(l1a_overflow), 16'(e_ovf));
    endtask

    // one BX: model evaluates at the edge, DUT sampled 1 ns later; requester drops on ack
    task automatic tick();
        @(posedge clk40);
        model_step();
        #1;
        check_all();
        if (command != IDLE)
            $display("bx=%0d orbit=%0d cmd=%02h l1a=%0b ecr_ack=%0b lrst_ack=%0b rej=%0b ovf=%0b",
                     bx_counter, orbit_counter, command, l1a_sent, ecr_ack, linkreset_ack,
                     calib_reject, l1a_overflow);
        if (e_l1a) n_l1a++;
        if (e_ecr) begin n_ecr++; ecr_req = 1'b0; end
        if (e_lrst) linkreset_req = 1'b0;
    endtask

    task automatic run_to(input int target);
        for (int i = 0; i < ORBIT_LEN + 2 && m_bx != target; i++) tick();
        chk("reach_bx", 16'(bx_counter), 16'(target));
    endtask

    task automatic pulse_l1a();
        l1a_req = 1'b1; tick(); l1a_req = 1'b0;
    endtask

    task automatic pulse_calib();
        calib_req = 1'b1; tick(); calib_req = 1'b0;
    endtask

    initial begin
        model_reset();
        enable = 1'b1;
        repeat (3) @(posedge clk40);
        #1;
        check_all();
        rstn = 1'b1;

        // idle orbits
        tick();
        chk("first_bx", 16'(bx_counter), 16'd0);
        chk("first_bcr", 16'(command), 16'(BCR));
        repeat (2 * ORBIT_LEN - 1) tick();
        chk("orbit_two", orbit_counter, 16'd2);
        chk("bx_last", 16'(bx_counter), 16'(ORBIT_LEN - 1));

        // plain L1A and L1A pushed past BCR
        run_to(100); pulse_l1a(); tick();
        chk("l1a_at_102", 16'(command), 16'(L1A));
        chk("l1a_sent_102", 16'(l1a_sent), 16'd1);
        run_to(ORBIT_LEN - 2); pulse_l1a(); tick();
        chk("bcr_wins", 16'(command), 16'(BCR));
        tick();
        chk("l1a_after_bcr", 16'(command), 16'(L1A));

        // calibration sequence, reject, and L1A colliding with calibration L1A
        run_to(200); pulse_calib(); tick();
        chk("cal_at_202", 16'(command), 16'(CAL));
        run_to(210); pulse_calib();
        chk("cal_reject", 16'(calib_reject), 16'd1);
        run_to(220); pulse_l1a(); tick();
        chk("cal_l1a_222", 16'(command), 16'(L1A));
        tick();
        chk("l1a_223", 16'(command), 16'(L1A));
        chk("bx_223", 16'(bx_counter), 16'd223);

        // calibration L1A landing on BCR
        run_to(ORBIT_LEN - 22); pulse_calib(); tick();
        chk("cal_at_3544", 16'(command), 16'(CAL));
        run_to(0);
        chk("cal_bcr", 16'(command), 16'(BCR));
        tick();
        chk("cal_l1a_bx1", 16'(command), 16'(L1A));
        repeat (3) tick();
        pulse_calib();
        chk("cal_idle_again", 16'(calib_reject), 16'd0);
        repeat (30) tick();

        // L1A burst with ECR held
        run_to(500);
        n_l1a = 0; n_ecr = 0;
        ecr_req = 1'b1;
        for (int i = 0; i < 9; i++) pulse_l1a();
        repeat (11) tick();
        chk("burst_l1a_count", 16'(n_l1a), 16'd9);
        chk("burst_ecr_count", 16'(n_ecr), 16'd1);

        // random traffic
        for (int i = 0; i < 6000; i++) begin
            l1a_req   = ($urandom_range(0, 7) == 0);
            calib_req = ($urandom_range(0, 39) == 0);
            if (!ecr_req && $urandom_range(0, 49) == 0) ecr_req = 1'b1;
            if (!linkreset_req && $urandom_range(0, 49) == 0) linkreset_req = 1'b1;
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            else if (!enable && $urandom_range(0, 19) == 0) enable = 1'b1;
            tick();
        end
        l1a_req = 1'b0; calib_req = 1'b0; ecr_req = 1'b0; linkreset_req = 1'b0; enable = 1'b1;
        repeat (40) tick();

        // link reset + calibration, then disable and reset mid-wait
        run_to(1000);
        linkreset_req = 1'b1;
        pulse_calib(); tick();
        chk("cal_before_lrst", 16'(command), 16'(CAL));
        tick();
        chk("lrst_cmd", 16'(command), 16'(LRST));
        chk("lrst_ack", 16'(linkreset_ack), 16'd1);
        repeat (5) tick();
        enable = 1'b0;
        repeat (2) tick();
        #5;
        rstn = 1'b0;
        #1;
        model_reset();
        check_all();
        @(posedge clk40);
        #1;
        check_all();
        rstn = 1'b1;
        enable = 1'b1;
        n_l1a = 0;
        repeat (30) tick();
        chk("no_stale_cal_l1a", 16'(n_l1a), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
